hdlc_tx_frame_ctrl: RTL

Transmit-side frame controller for the HDLC core. On a start request it fetches a frame from the Tx data buffer and serializes it onto `Tx`: opening flag, zero-stuffed payload, zero-stuffed X.25 FCS, closing flag. It also handles abort requests and drives the all-ones idle pattern. It sits between the Tx register file/buffer and the serial line, and owns `Tx_ValidFrame` and `Tx_AbortedTrans`.

---
 rtl/hdlc_pkg.sv | 26 ++
 rtl/hdlc_tx_fcs.sv | 31 +++
 rtl/hdlc_tx_frame_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: transmit FSM states, framing constants and the
// CRC-16/X.25 single-bit update used by the FCS generator.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_FLAG = 3'd1,
    DATA       = 3'd2,
    FCS        = 3'd3,
    END_FLAG   = 3'd4,
    ABORT      = 3'd5
  } tx_state_t;

  localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
  localparam logic [7:0]  HDLC_ABORT = 8'hFE;
  localparam logic [15:0] FCS_POLY   = 16'h8408;
  localparam logic [15:0] FCS_INIT   = 16'hFFFF;

  // Reflected CRC step: one line bit, LSB-first order
  function automatic logic [15:0] fcsStep(input logic [15:0] crc, input logic bitIn);
    logic fb;
    fb = crc[0] ^ bitIn;
    fcsStep = {1'b0, crc[15:1]} ^ (fb ? FCS_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_tx_fcs.sv
// Bit-serial CRC-16/X.25 generator; Fcs is the complemented register, ready
// to be sent low byte first.
module hdlc_tx_fcs
  import hdlc_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Init,
  input  logic        Enable,
  input  logic        DataBit,
  output logic [15:0] Fcs
);

  logic [15:0] crcR;

  // CRC register: Init has priority over a data bit
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      crcR <= FCS_INIT;
    end else if (Init) begin
      crcR <= FCS_INIT;
    end else if (Enable) begin
      crcR <= fcsStep(crcR, DataBit);
    end else begin
      crcR <= crcR;
    end
  end

  assign Fcs = ~crcR;

endmodule

// File: rtl/hdlc_tx_frame_ctrl.sv
// HDLC transmit framer: flag, zero-stuffed payload and FCS, closing flag,
// abort sequence and idle ones. Every line-side output is a register.
module hdlc_tx_frame_ctrl
  import hdlc_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 126,
  parameter int ADDR_W          = 7
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tx_Enable,
  input  logic              Tx_AbortFrame,
  input  logic [7:0]        Tx_FrameSize,
  output logic              Tx_RdBuff,
  output logic [ADDR_W-1:0] Tx_RdAddr,
  input  logic [7:0]        Tx_DataOutBuff,
  output logic              Tx,
  output logic              Tx_ValidFrame,
  output logic              Tx_AbortedTrans,
  output logic              Tx_Done,
  output logic              Tx_Busy
);

  localparam logic [7:0] MAX_SIZE = 8'(MAX_FRAME_BYTES);

  tx_state_t         stateR, stateN;
  logic [2:0]        bitCntR, bitCntN, onesR, onesN;
  logic [7:0]        byteCntR, byteCntN, sizeR, sizeN, shiftR, shiftN, nextByteR;
  logic              txR, txN, validR, validN, abortedR, abortedN, doneR, doneN;
  logic              rdBuffR, rdBuffN, rdPendR;
  logic [ADDR_W-1:0] rdAddrR, rdAddrN;
  logic              fcsInit, fcsEn, fcsBit, nextBit, sizeOk;
  logic [15:0]       fcsOut;

  hdlc_tx_fcs u_fcs (
    .Clk    (Clk),
    .Rst    (Rst),
    .Init   (fcsInit),
    .Enable (fcsEn),
    .DataBit(fcsBit),
    .Fcs    (fcsOut)
  );

  assign sizeOk = (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= MAX_SIZE);

  // Next-state and next-output logic; shiftR rotates so bit [1] is the next line bit
  always_comb begin
    stateN = stateR;   bitCntN = bitCntR; byteCntN = byteCntR; sizeN = sizeR;
    shiftN = shiftR;   onesN = onesR;     txN = txR;           validN = validR;
    abortedN = abortedR; doneN = 1'b0;    rdBuffN = 1'b0;      rdAddrN = rdAddrR;
    fcsInit = 1'b0;    fcsEn = 1'b0;      fcsBit = 1'b0;       nextBit = 1'b0;
    case (stateR)
      IDLE: begin
        txN = 1'b1;
        if (Tx_Enable && sizeOk) begin
          stateN   = START_FLAG;
          sizeN    = Tx_FrameSize;
          abortedN = 1'b0;
          fcsInit  = 1'b1;
          rdBuffN  = 1'b1;
          rdAddrN  = {ADDR_W{1'b0}};
          validN   = 1'b1;
          bitCntN  = 3'd0;
          shiftN   = HDLC_FLAG;
          txN      = HDLC_FLAG[0];
        end else begin
          stateN = IDLE;
        end
      end
      START_FLAG, END_FLAG, ABORT: begin
        if (bitCntR != 3'd7) begin
          bitCntN = bitCntR + 3'd1;
          shiftN  = {shiftR[0], shiftR[7:1]};
          txN     = shiftR[1];
        end else if (stateR == START_FLAG) begin
          stateN   = DATA;
          bitCntN  = 3'd0;
          byteCntN = 8'd0;
          shiftN   = nextByteR;
          txN      = nextByteR[0];
          onesN    = {2'b00, nextByteR[0]};
          fcsEn    = 1'b1;
          fcsBit   = nextByteR[0];
          if (sizeR > 8'd1) begin
            rdBuffN = 1'b1;
            rdAddrN = ADDR_W'(8'd1);
          end else begin
            rdBuffN = 1'b0;
          end
        end else begin
          stateN = IDLE;
          txN    = 1'b1;
          validN = 1'b0;
          doneN  = (stateR == END_FLAG);
        end
      end
      DATA, FCS: begin
        if (onesR == 3'd5) begin
          // Inserted zero: bit stream and bit counter hold
          txN   = 1'b0;
          onesN = 3'd0;
        end else begin
          if (bitCntR != 3'd7) begin
            bitCntN = bitCntR + 3'd1;
            shiftN  = {shiftR[0], shiftR[7:1]};
            nextBit = shiftR[1];
            fcsEn   = (stateR == DATA);
          end else begin
            bitCntN = 3'd0;
            if (stateR == DATA) begin
              if (byteCntR == sizeR - 8'd1) begin
                stateN   = FCS;
                byteCntN = 8'd0;
                shiftN   = fcsOut[7:0];
              end else begin
                byteCntN = byteCntR + 8'd1;
                shiftN   = nextByteR;
                fcsEn    = 1'b1;
                if (byteCntR + 8'd2 < sizeR) begin
                  rdBuffN = 1'b1;
                  rdAddrN = ADDR_W'(byteCntR + 8'd2);
                end else begin
                  rdBuffN = 1'b0;
                end
              end
            end else if (byteCntR == 8'd0) begin
              byteCntN = 8'd1;
              shiftN   = fcsOut[15:8];
            end else begin
              stateN = END_FLAG;
              shiftN = HDLC_FLAG;
            end
            nextBit = shiftN[0];
          end
          txN    = nextBit;
          fcsBit = nextBit;
          onesN  = nextBit ? (onesR + 3'd1) : 3'd0;
        end
      end
      default: begin
        stateN = IDLE;
        txN    = 1'b1;
        validN = 1'b0;
      end
    endcase
    if (Tx_AbortFrame && (stateR inside {START_FLAG, DATA, FCS, END_FLAG})) begin
      stateN   = ABORT;
      bitCntN  = 3'd0;
      shiftN   = HDLC_ABORT;
      txN      = HDLC_ABORT[0];
      validN   = 1'b0;
      abortedN = 1'b1;
      rdBuffN  = 1'b0;
      doneN    = 1'b0;
      fcsEn    = 1'b0;
    end else begin
      abortedN = abortedN;
    end
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stateR <= IDLE;     bitCntR <= 3'd0;  byteCntR <= 8'd0; sizeR <= 8'd0;
      shiftR <= 8'hFF;    onesR <= 3'd0;    txR <= 1'b1;      validR <= 1'b0;
      abortedR <= 1'b0;   doneR <= 1'b0;    rdBuffR <= 1'b0;  rdAddrR <= {ADDR_W{1'b0}};
    end else begin
      stateR <= stateN;   bitCntR <= bitCntN; byteCntR <= byteCntN; sizeR <= sizeN;
      shiftR <= shiftN;   onesR <= onesN;     txR <= txN;           validR <= validN;
      abortedR <= abortedN; doneR <= doneN;   rdBuffR <= rdBuffN;   rdAddrR <= rdAddrN;
    end
  end

  // Capture buffer data the cycle after each read strobe
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdPendR   <= 1'b0;
      nextByteR <= 8'h00;
    end else begin
      rdPendR   <= rdBuffR;
      nextByteR <= rdPendR ? Tx_DataOutBuff : nextByteR;
    end
  end

  assign Tx              = txR;
  assign Tx_ValidFrame   = validR;
  assign Tx_AbortedTrans = abortedR;
  assign Tx_Done         = doneR;
  assign Tx_RdBuff       = rdBuffR;
  assign Tx_RdAddr       = rdAddrR;
  assign Tx_Busy         = (stateR != IDLE);

endmodule
